// File: rtl/fir_ram_ctrl.sv
// Sequencer for a RAM-based MAC FIR channel: zero-fills the circular sample history, steps read
// addresses for one MAC pass per sample, then scales and saturates the accumulator. Macro: FIR_CTRL_ROUND_EN.
module fir_ram_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned TAPS       = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic                  smp_wr_o,
    output logic [ADDR_WIDTH-1:0] smp_waddr_o,
    output logic [DATA_WIDTH-1:0] smp_wdata_o,
    output logic [ADDR_WIDTH-1:0] smp_raddr_o,
    output logic [ADDR_WIDTH-1:0] coef_raddr_o,
    output logic                  mac_clr_o,
    output logic                  mac_ena_o,
    input  logic [ACC_WIDTH-1:0]  acc_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o
);

    localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_A   = ADDR_WIDTH + 1;
    localparam int unsigned CNT_B   = $clog2(RD_LAT + 3);
    localparam int unsigned CNT_W   = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam int unsigned EXT_W   = ACC_WIDTH + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX =
        $signed((EXT_W'(1) << (DATA_WIDTH - 1)) - EXT_W'(1));
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`ifdef FIR_CTRL_ROUND_EN
    localparam logic [EXT_W-1:0] RND_HALF = EXT_W'(1) << (COEF_WIDTH - 2);
`endif

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic                  issue_q;
    logic [RD_LAT-1:0]     ena_sr_q;

    // Drop the fractional coefficient bits, then clamp to the output range.
    function automatic logic [DATA_WIDTH-1:0] scale(input logic [ACC_WIDTH-1:0] acc);
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] shifted;
        ext = $signed({acc[ACC_WIDTH-1], acc});
`ifdef FIR_CTRL_ROUND_EN
        ext = ext + $signed(RND_HALF);
`endif
        shifted = ext >>> (COEF_WIDTH - 1);
        if (shifted > SAT_MAX) begin
            return DATA_WIDTH'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            return DATA_WIDTH'(SAT_MIN);
        end
        return DATA_WIDTH'(shifted);
    endfunction

    // Issue flag delayed by the RAM read latency so enable lines up with read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ena_sr_q <= '0;
        end else begin
            ena_sr_q <= RD_LAT'({ena_sr_q, issue_q});
        end
    end

    assign mac_ena_o = ena_sr_q[RD_LAT-1];

    // Outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            issue_q      <= 1'b0;
            s_ready_o    <= 1'b0;
            smp_wr_o     <= 1'b0;
            smp_waddr_o  <= '0;
            smp_wdata_o  <= '0;
            smp_raddr_o  <= '0;
            coef_raddr_o <= '0;
            mac_clr_o    <= 1'b0;
            m_valid_o    <= 1'b0;
            m_data_o     <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == CNT_W'(DEPTH)) begin
                        state_q   <= ST_IDLE;
                        smp_wr_o  <= 1'b0;
                        s_ready_o <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        smp_wr_o    <= 1'b1;
                        smp_waddr_o <= ADDR_WIDTH'(cnt_q);
                        smp_wdata_o <= '0;
                        cnt_q       <= cnt_q + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    m_valid_o <= 1'b0;
                    if (s_valid_i && s_ready_o) begin
                        state_q     <= ST_WRITE;
                        s_ready_o   <= 1'b0;
                        smp_wr_o    <= 1'b1;
                        smp_waddr_o <= wr_ptr_q;
                        smp_wdata_o <= s_data_i;
                        mac_clr_o   <= 1'b1;
                    end else begin
                        s_ready_o <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_q      <= ST_RUN;
                    smp_wr_o     <= 1'b0;
                    mac_clr_o    <= 1'b0;
                    smp_raddr_o  <= wr_ptr_q;
                    coef_raddr_o <= '0;
                    issue_q      <= 1'b1;
                    cnt_q        <= '0;
                end
                ST_RUN: begin
                    if (cnt_q == CNT_W'(TAPS - 1)) begin
                        state_q <= ST_DRAIN;
                        issue_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q        <= cnt_q + CNT_W'(1);
                        smp_raddr_o  <= smp_raddr_o - ADDR_WIDTH'(1);
                        coef_raddr_o <= coef_raddr_o + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    // Last drain cycle: the final product has reached the accumulator.
                    if (cnt_q == CNT_W'(RD_LAT + 1)) begin
                        state_q   <= ST_IDLE;
                        m_valid_o <= 1'b1;
                        m_data_o  <= scale(acc_i);
                        wr_ptr_q  <= wr_ptr_q + ADDR_WIDTH'(1);
                        s_ready_o <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_ram_ctrl.sv
// Bench for fir_ram_ctrl: behavioural sample/coef RAMs and MAC around the DUT, compared against a
// tap-sum reference model over the accepted sample history.
module tb_fir_ram_ctrl;

    localparam int unsigned DW     = 16;
    localparam int unsigned CW     = 16;
    localparam int unsigned TAPS   = 4;
    localparam int unsigned AW     = 5;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned ACC_W  = DW + CW + $clog2(TAPS);
    localparam int unsigned DEPTH  = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              s_valid_i;
    logic [DW-1:0]     s_data_i;
    logic              s_ready_o;
    logic              smp_wr_o;
    logic [AW-1:0]     smp_waddr_o;
    logic [DW-1:0]     smp_wdata_o;
    logic [AW-1:0]     smp_raddr_o;
    logic [AW-1:0]     coef_raddr_o;
    logic              mac_clr_o;
    logic              mac_ena_o;
    logic [ACC_W-1:0]  acc_i;
    logic              m_valid_o;
    logic [DW-1:0]     m_data_o;

    always #5 clk_i = ~clk_i;

    fir_ram_ctrl #(
        .DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .smp_wr_o(smp_wr_o), .smp_waddr_o(smp_waddr_o), .smp_wdata_o(smp_wdata_o),
        .smp_raddr_o(smp_raddr_o), .coef_raddr_o(coef_raddr_o),
        .mac_clr_o(mac_clr_o), .mac_ena_o(mac_ena_o), .acc_i(acc_i),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o)
    );

    // Environment: synchronous RAMs (read latency 1) and a two-stage MAC.
    logic signed [DW-1:0]    smp_mem  [DEPTH];
    logic signed [CW-1:0]    coef_mem [DEPTH];
    logic signed [DW-1:0]    smp_rd_q;
    logic signed [CW-1:0]    coef_rd_q;
    logic signed [DW+CW-1:0] prod_q;
    logic                    prod_v_q;
    logic signed [ACC_W-1:0] acc_q;

    always @(posedge clk_i) begin
        if (smp_wr_o) smp_mem[smp_waddr_o] <= smp_wdata_o;
        smp_rd_q  <= smp_mem[smp_raddr_o];
        coef_rd_q <= coef_mem[coef_raddr_o];
    end

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
        end else if (mac_clr_o) begin
            prod_v_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            prod_q   <= smp_rd_q * coef_rd_q;
            prod_v_q <= mac_ena_o;
            if (prod_v_q) acc_q <= acc_q + prod_q;
        end
    end

    assign acc_i = acc_q;

    int n_tests = 0;
    int n_fail  = 0;
    int overlap = 0;
    int exp_ptr = 0;
    bit saw31   = 1'b0;
    bit wrap_seen = 1'b0;
    logic signed [DW-1:0] hist [$];

    always @(posedge clk_i) if (mac_clr_o && mac_ena_o) overlap++;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic signed [DW-1:0] sat_scale(input longint a);
        longint x;
`ifdef FIR_CTRL_ROUND_EN
        x = (a + 16384) >>> 15;
`else
        x = a >>> 15;
`endif
        if (x > 32767) x = 32767;
        if (x < -32768) x = -32768;
        return DW'(x);
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < int'(TAPS); i++) hist.push_back('0);
        exp_ptr = 0;
    endfunction

    // y[n] = sat(scale(sum_k coef[k] * x[n-k])) over the newest TAPS samples.
    function automatic logic signed [DW-1:0] model_step(input logic signed [DW-1:0] x);
        longint acc = 0;
        hist.push_front(x);
        if (hist.size() > int'(TAPS)) void'(hist.pop_back());
        for (int k = 0; k < int'(TAPS); k++) acc += longint'(hist[k]) * longint'(coef_mem[k]);
        return sat_scale(acc);
    endfunction

    task automatic init_check();
        int n = 0, writes = 0, addr_err = 0, data_err = 0;
        while (!s_ready_o && n < 60) begin
            @(negedge clk_i);
            n++;
            if (smp_wr_o) begin
                if (smp_waddr_o != AW'(writes)) addr_err++;
                if (smp_wdata_o != '0) data_err++;
                writes++;
            end
        end
        chk("init_ready", longint'(s_ready_o), 1);
        chk("init_cycles", n, 33);
        chk("init_writes", writes, 32);
        chk("init_addr_err", addr_err, 0);
        chk("init_data_err", data_err, 0);
    endtask

    task automatic do_pass(input logic signed [DW-1:0] x, output logic signed [DW-1:0] y);
        int n = 0;
        while (!s_ready_o && n < 100) begin @(negedge clk_i); n++; end
        chk("ready_wait", longint'(s_ready_o), 1);
        s_valid_i = 1'b1;
        s_data_i  = x;
        @(negedge clk_i);
        s_valid_i = 1'b0;
        chk("write_strobe", longint'(smp_wr_o), 1);
        chk("write_addr", longint'(smp_waddr_o), exp_ptr);
        chk("write_data", longint'($signed(smp_wdata_o)), longint'(x));
        if (smp_waddr_o == AW'(31)) saw31 = 1'b1;
        else if (saw31 && smp_waddr_o == '0) wrap_seen = 1'b1;
        n = 0;
        while (!m_valid_o && n < 50) begin @(negedge clk_i); n++; end
        chk("m_valid_wait", longint'(m_valid_o), 1);
        y = $signed(m_data_o);
        exp_ptr = (exp_ptr + 1) % DEPTH;
    endtask

    typedef struct {
        logic signed [DW-1:0] x;
        logic signed [DW-1:0] y;
    } vec_t;

    initial begin
        vec_t                 imp [5];
        logic signed [DW-1:0] x, y, e;
        logic [4:0]           act, ev;
        bit                   mv_seen;
        int                   n;

        for (int i = 0; i < int'(DEPTH); i++) coef_mem[i] = '0;
        coef_mem[0] = 16'sd16384;
        coef_mem[1] = 16'sd8192;
        coef_mem[2] = -16'sd8192;
        coef_mem[3] = 16'sd4096;
`ifdef FIR_CTRL_ROUND_EN
        imp[0] = '{16'sd32767, 16'sd16384};
        imp[1] = '{16'sd0, 16'sd8192};
        imp[2] = '{16'sd0, -16'sd8192};
        imp[3] = '{16'sd0, 16'sd4096};
        imp[4] = '{16'sd0, 16'sd0};
`else
        imp[0] = '{16'sd32767, 16'sd16383};
        imp[1] = '{16'sd0, 16'sd8191};
        imp[2] = '{16'sd0, -16'sd8192};
        imp[3] = '{16'sd0, 16'sd4095};
        imp[4] = '{16'sd0, 16'sd0};
`endif

        rst_i = 1'b1; s_valid_i = 1'b0; s_data_i = '0;
        repeat (3) @(negedge clk_i);
        chk("reset_outputs", longint'({s_ready_o, smp_wr_o, smp_waddr_o, smp_wdata_o, smp_raddr_o,
            coef_raddr_o, mac_clr_o, mac_ena_o, m_valid_o, m_data_o}), 0);
        rst_i = 1'b0;
        model_reset();
        init_check();

        for (int i = 0; i < 5; i++) begin
            void'(model_step(imp[i].x));
            do_pass(imp[i].x, y);
            chk($sformatf("impulse_%0d", i), longint'(y), longint'(imp[i].y));
        end

        // Cycle-accurate pass; s_valid_i stays high while busy and must be ignored.
        n = 0;
        while (!s_ready_o && n < 100) begin @(negedge clk_i); n++; end
        s_valid_i = 1'b1;
        s_data_i  = 16'sd1234;
        e = model_step(16'sd1234);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            act = {s_ready_o, smp_wr_o, mac_clr_o, mac_ena_o, m_valid_o};
            ev  = {c >= 9, c == 1, c == 1, (c >= 3 && c <= 6), c == 9};
            chk($sformatf("timing_c%0d", c), longint'(act), longint'(ev));
            if (c == 1) chk("timing_waddr", longint'(smp_waddr_o), exp_ptr);
            if (c == 9) chk("timing_data", longint'($signed(m_data_o)), longint'(e));
            if (c < 9) s_data_i = DW'($urandom);
            else s_valid_i = 1'b0;
        end
        exp_ptr = (exp_ptr + 1) % DEPTH;

        for (int i = 0; i < 40; i++) begin
            x = DW'($urandom);
            e = model_step(x);
            do_pass(x, y);
            chk($sformatf("stream_%0d", i), longint'(y), longint'(e));
        end
        chk("waddr_wrap", longint'(wrap_seen), 1);

        for (int k = 0; k < int'(TAPS); k++) coef_mem[k] = 16'sd32767;
        for (int i = 0; i < 4; i++) begin
            e = model_step(16'sd32767);
            do_pass(16'sd32767, y);
            chk($sformatf("sat_pos_%0d", i), longint'(y), longint'(e));
        end
        chk("sat_pos_final", longint'(y), 32767);
        for (int i = 0; i < 4; i++) begin
            e = model_step(-16'sd32767);
            do_pass(-16'sd32767, y);
            chk($sformatf("sat_neg_%0d", i), longint'(y), longint'(e));
        end
        chk("sat_neg_final", longint'(y), -32768);
        coef_mem[0] = 16'sd16384;
        coef_mem[1] = 16'sd8192;
        coef_mem[2] = -16'sd8192;
        coef_mem[3] = 16'sd4096;

        // Reset in the middle of a MAC pass.
        n = 0;
        while (!s_ready_o && n < 100) begin @(negedge clk_i); n++; end
        s_valid_i = 1'b1;
        s_data_i  = 16'sd32767;
        @(negedge clk_i);
        s_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("abort_in_run", longint'(mac_ena_o), 1);
        rst_i = 1'b1;
        #1;
        chk("abort_outputs", longint'({s_ready_o, smp_wr_o, smp_waddr_o, smp_wdata_o, smp_raddr_o,
            coef_raddr_o, mac_clr_o, mac_ena_o, m_valid_o, m_data_o}), 0);
        mv_seen = 1'b0;
        repeat (2) begin @(negedge clk_i); mv_seen |= m_valid_o; end
        rst_i = 1'b0;
        model_reset();
        saw31 = 1'b0;
        init_check();
        chk("abort_no_valid", longint'(mv_seen), 0);
        for (int i = 0; i < 5; i++) begin
            void'(model_step(imp[i].x));
            do_pass(imp[i].x, y);
            chk($sformatf("post_reset_impulse_%0d", i), longint'(y), longint'(imp[i].y));
        end

        chk("clr_ena_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
